// File: rtl/codec_cfg_pkg.sv
// Shared configuration for the codec bring-up sequencer: register table,
// PLL lock location and the sequencer state encoding.
package codec_cfg_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } reg_wr_t;

    localparam int NUM_REGS = 8;
    localparam int PLL_REGS = 3;
    localparam int IDX_W    = $clog2(NUM_REGS + 1);
    localparam int ROM_AW   = $clog2(NUM_REGS);

    localparam logic [15:0] PLL_LOCK_ADDR = 16'h4007;
    localparam int          PLL_LOCK_BIT  = 1;

    // PLL setup entries come first; the sequencer polls for lock after them.
    localparam reg_wr_t REG_TABLE [NUM_REGS] = '{
        '{16'h4000, 8'h01},
        '{16'h4002, 8'h7D},
        '{16'h4003, 8'h12},
        '{16'h4015, 8'h01},
        '{16'h4016, 8'h00},
        '{16'h4019, 8'h63},
        '{16'h401C, 8'h21},
        '{16'h4029, 8'h03}
    };

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_STARTUP,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_POLL_ISSUE,
        ST_POLL_WAIT,
        ST_POLL_GAP,
        ST_WAIT_LR,
        ST_RUN,
        ST_FAULT
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/codec_reg_rom.sv
// Combinational lookup of the codec register table; out-of-range indices read zero.
module codec_reg_rom
    import codec_cfg_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output reg_wr_t          o_entry
);

    always_comb begin
        o_entry = '0;
        if (int'(i_idx) < NUM_REGS) begin
            o_entry = REG_TABLE[i_idx[ROM_AW-1:0]];
        end
    end

endmodule

// File: rtl/codec_init_seq.sv
// Codec bring-up sequencer: power-up wait, register writes over an I2C command
// port, PLL lock polling, then enable the serdes on the first LRCLK falling edge.
module codec_init_seq
    import codec_cfg_pkg::*;
#(
    parameter int STARTUP_CYCLES  = 1_000_000,
    parameter int POLL_GAP_CYCLES = 10_000,
    parameter int POLL_MAX        = 256,
    parameter int RETRY_MAX       = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_rnw,
    output logic [15:0] cmd_addr,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    input  logic        rsp_err,
    input  logic        lrclk,
    output logic        enabled,
    output logic        busy,
    output logic        fault,
    output state_t      o_dbg_state
);

    // Handshake: a command transfers on the cycle cmd_valid && cmd_ready; cmd_valid
    // and its payload stay stable until then. rsp_valid is a one-cycle pulse that
    // is only honoured in the *_WAIT states.

    localparam int DLY_W   = $clog2(max_int(STARTUP_CYCLES, POLL_GAP_CYCLES) + 1);
    localparam int POLL_W  = max_int(1, $clog2(POLL_MAX + 1));
    localparam int RETRY_W = max_int(1, $clog2(RETRY_MAX + 1));

    localparam logic [DLY_W-1:0]   STARTUP_LAST = DLY_W'(STARTUP_CYCLES - 1);
    localparam logic [DLY_W-1:0]   GAP_LAST     = DLY_W'(POLL_GAP_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_LIM     = POLL_W'(POLL_MAX);
    localparam logic [RETRY_W-1:0] RETRY_LIM    = RETRY_W'(RETRY_MAX);
    localparam logic [IDX_W-1:0]   PLL_IDX      = IDX_W'(PLL_REGS);
    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_REGS);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [POLL_W-1:0]  r_poll;
    logic [RETRY_W-1:0] r_retry;
    logic [DLY_W-1:0]   r_delay;
    logic               r_lr_sync1;
    logic               r_lr_sync2;
    logic               r_lr_dly;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [POLL_W-1:0]  w_poll_nxt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [DLY_W-1:0]   w_delay_nxt;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [POLL_W-1:0]  w_poll_inc;
    logic               w_lr_fall;
    logic               w_rdata_unused;
    reg_wr_t            w_entry;

    codec_reg_rom u_rom (
        .i_idx   (r_idx),
        .o_entry (w_entry)
    );

    assign w_idx_inc      = r_idx + 1'b1;
    assign w_poll_inc     = (r_poll == POLL_LIM) ? r_poll : r_poll + 1'b1;
    assign w_lr_fall      = r_lr_dly & ~r_lr_sync2;
    assign w_rdata_unused = ^(rsp_rdata & ~(8'd1 << PLL_LOCK_BIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_poll     <= '0;
            r_retry    <= '0;
            r_delay    <= '0;
            r_lr_sync1 <= 1'b1;
            r_lr_sync2 <= 1'b1;
            r_lr_dly   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_poll     <= w_poll_nxt;
            r_retry    <= w_retry_nxt;
            r_delay    <= w_delay_nxt;
            r_lr_sync1 <= lrclk;
            r_lr_sync2 <= r_lr_sync1;
            r_lr_dly   <= r_lr_sync2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_poll_nxt  = r_poll;
        w_retry_nxt = r_retry;
        w_delay_nxt = '0;
        cmd_valid   = 1'b0;
        cmd_rnw     = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_STARTUP;
            ST_STARTUP: begin
                if (r_delay == STARTUP_LAST) w_state_nxt = ST_WR_ISSUE;
                else                         w_delay_nxt = r_delay + 1'b1;
            end
            ST_WR_ISSUE: begin
                cmd_valid = 1'b1;
                cmd_addr  = w_entry.addr;
                cmd_wdata = w_entry.data;
                if (cmd_ready) w_state_nxt = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (rsp_valid && rsp_err) begin
                    if (r_retry == RETRY_LIM) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = ST_WR_ISSUE;
                    end
                end else if (rsp_valid) begin
                    w_retry_nxt = '0;
                    w_idx_nxt   = w_idx_inc;
                    if (w_idx_inc == PLL_IDX)       w_state_nxt = ST_POLL_ISSUE;
                    else if (w_idx_inc == LAST_IDX) w_state_nxt = ST_WAIT_LR;
                    else                            w_state_nxt = ST_WR_ISSUE;
                end
            end
            ST_POLL_ISSUE: begin
                cmd_valid = 1'b1;
                cmd_rnw   = 1'b1;
                cmd_addr  = PLL_LOCK_ADDR;
                if (cmd_ready) w_state_nxt = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                // An errored read is retried immediately and never counts as a poll.
                if (rsp_valid && rsp_err) begin
                    if (r_retry == RETRY_LIM) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = ST_POLL_ISSUE;
                    end
                end else if (rsp_valid) begin
                    w_retry_nxt = '0;
                    if (rsp_rdata[PLL_LOCK_BIT]) begin
                        w_state_nxt = ST_WR_ISSUE;
                    end else begin
                        w_poll_nxt  = w_poll_inc;
                        w_state_nxt = (w_poll_inc == POLL_LIM) ? ST_FAULT : ST_POLL_GAP;
                    end
                end
            end
            ST_POLL_GAP: begin
                if (r_delay == GAP_LAST) w_state_nxt = ST_POLL_ISSUE;
                else                     w_delay_nxt = r_delay + 1'b1;
            end
            ST_WAIT_LR: if (w_lr_fall) w_state_nxt = ST_RUN;
            ST_RUN:     w_state_nxt = ST_RUN;
            ST_FAULT:   w_state_nxt = ST_FAULT;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    assign enabled     = (r_state == ST_RUN);
    assign fault       = (r_state == ST_FAULT);
    assign busy        = (r_state != ST_RUN) && (r_state != ST_FAULT);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: a scripted I2C responder plus a command-list model
// of the bring-up sequence built from the register table and response plan.
module tb_codec_init_seq;
    import codec_cfg_pkg::*;

    localparam int STARTUP = 100;
    localparam int GAP     = 20;
    localparam int PMAX    = 4;
    localparam int RMAX    = 3;

    typedef struct packed {
        logic        rnw;
        logic [15:0] addr;
        logic [7:0]  data;
    } cmd_t;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        cmd_rnw;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid = 1'b0;
    logic [7:0]  rsp_rdata = 8'h00;
    logic        rsp_err = 1'b0;
    logic        lrclk = 1'b1;
    logic        enabled;
    logic        busy;
    logic        fault;
    state_t      dbg_state;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    cmd_t exp_q[$];
    rsp_t plan_q[$];
    cmd_t obs_q[$];
    int   obs_cyc_q[$];
    int   wr_err[NUM_REGS];
    bit   exp_fault;
    int   ready_mode = 1;
    int   ready_mode_sel = 1;
    bit   slow_rsp = 1'b0;
    bit   lr_free = 1'b0;
    int   lr_cnt = 0;

    codec_init_seq #(
        .STARTUP_CYCLES  (STARTUP),
        .POLL_GAP_CYCLES (GAP),
        .POLL_MAX        (PMAX),
        .RETRY_MAX       (RMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rnw     (cmd_rnw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .lrclk       (lrclk),
        .enabled     (enabled),
        .busy        (busy),
        .fault       (fault),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- I2C responder / command monitor ----------------
    initial begin : responder
        bit   pend;
        bit   stale;
        int   pend_lat;
        int   pidx;
        cmd_t c;
        pend = 1'b0;
        stale = 1'b0;
        pend_lat = 0;
        pidx = 0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            rsp_rdata = 8'($urandom);
            if (reset) begin
                stale = pend;
                pidx  = 0;
                obs_q.delete();
                obs_cyc_q.delete();
            end
            if (pend) begin
                if (pend_lat == 0) begin
                    pend      = 1'b0;
                    rsp_valid = 1'b1;
                    if (stale) begin
                        rsp_err = 1'b1;
                    end else if (pidx < plan_q.size()) begin
                        rsp_err   = plan_q[pidx].err;
                        rsp_rdata = plan_q[pidx].rdata;
                        pidx++;
                    end else begin
                        rsp_rdata = 8'h02;
                    end
                    stale = 1'b0;
                end else begin
                    pend_lat--;
                end
            end
            case (ready_mode)
                0:       cmd_ready = 1'b0;
                1:       cmd_ready = 1'b1;
                default: cmd_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (!reset && cmd_valid && cmd_ready) begin
                c = {cmd_rnw, cmd_addr, cmd_wdata};
                obs_q.push_back(c);
                obs_cyc_q.push_back(cyc);
                if (!pend) begin
                    pend     = 1'b1;
                    pend_lat = slow_rsp ? 10 : int'($urandom_range(0, 3));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        if (lr_free) begin
            lr_cnt++;
            if (lr_cnt >= 3) begin
                lr_cnt = 0;
                lrclk  = ~lrclk;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic add_cmd(input cmd_t c, input int nerr, input logic [7:0] ok_data, inout bit dead);
        rsp_t r;
        if (dead) return;
        for (int k = 0; k < nerr && k <= RMAX; k++) begin
            r = {1'b1, 8'($urandom)};
            exp_q.push_back(c);
            plan_q.push_back(r);
        end
        if (nerr > RMAX) begin
            dead = 1'b1;
        end else begin
            r = {1'b0, ok_data};
            exp_q.push_back(c);
            plan_q.push_back(r);
        end
    endtask

    // nz lock-0 answers precede the lock-1 answer; each poll read fails poll_err times first.
    task automatic build_plan(input int nz, input int poll_err);
        bit         dead;
        logic [7:0] d;
        cmd_t       c;
        exp_q.delete();
        plan_q.delete();
        dead = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == PLL_REGS) begin
                for (int p = 0; p < PMAX && !dead; p++) begin
                    d = 8'($urandom);
                    d[PLL_LOCK_BIT] = (p >= nz);
                    c = {1'b1, PLL_LOCK_ADDR, 8'h00};
                    add_cmd(c, poll_err, d, dead);
                    if (p >= nz) break;
                    if (p == PMAX - 1) dead = 1'b1;
                end
            end
            c = {1'b0, REG_TABLE[i].addr, REG_TABLE[i].data};
            add_cmd(c, wr_err[i], 8'($urandom), dead);
        end
        exp_fault = dead;
    endtask

    task automatic clear_errs();
        for (int i = 0; i < NUM_REGS; i++) wr_err[i] = 0;
    endtask

    // ---------------- sequence steps ----------------
    task automatic start_seq(input string name, input bit stall);
        int   n;
        bit   stable;
        cmd_t c0;
        cmd_t cn;
        ready_mode = stall ? 0 : ready_mode_sel;
        reset = 1'b1;
        repeat (3) step();
        check({name, "_rst_busy"}, busy, 1);
        check({name, "_rst_valid"}, cmd_valid, 0);
        check({name, "_rst_en"}, enabled, 0);
        check({name, "_rst_fault"}, fault, 0);
        reset   = 1'b0;
        lr_free = 1'b1;
        n = 0;
        while (!cmd_valid && n < STARTUP + 50) begin
            step();
            n++;
        end
        lr_free = 1'b0;
        lrclk   = 1'b1;
        check({name, "_startup_len"}, n, STARTUP + 1);
        if (stall) begin
            c0 = {cmd_rnw, cmd_addr, cmd_wdata};
            stable = 1'b1;
            repeat (50) begin
                step();
                cn = {cmd_rnw, cmd_addr, cmd_wdata};
                if (!cmd_valid || cn !== c0) stable = 1'b0;
            end
            check({name, "_stall_hold"}, stable, 1);
            ready_mode = ready_mode_sel;
        end
    endtask

    task automatic finish_seq(input string name);
        int   n;
        cmd_t got;
        n = 0;
        while (!(dbg_state inside {ST_WAIT_LR, ST_RUN, ST_FAULT}) && n < 20000) begin
            step();
            n++;
        end
        check({name, "_reach_end"}, (n < 20000), 1);
        if (!exp_fault) begin
            repeat (4) step();
            check({name, "_pre_edge_en"}, enabled, 0);
            check({name, "_pre_edge_busy"}, busy, 1);
            lrclk = 1'b0;
            n = 0;
            while (!enabled && n < 10) begin
                step();
                n++;
            end
            check({name, "_en_latency"}, n, 3);
            check({name, "_run_busy"}, busy, 0);
            check({name, "_run_fault"}, fault, 0);
            check({name, "_run_valid"}, cmd_valid, 0);
        end else begin
            repeat (2) step();
            check({name, "_fault_flag"}, fault, 1);
            check({name, "_fault_busy"}, busy, 0);
            check({name, "_fault_valid"}, cmd_valid, 0);
            lrclk = 1'b0;
            repeat (6) step();
            check({name, "_fault_en"}, enabled, 0);
        end
        check({name, "_n_cmds"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            got = obs_q[i];
            if (exp_q[i].rnw) got.data = exp_q[i].data;
            check($sformatf("%s_cmd%0d", name, i), got, exp_q[i]);
        end
        for (int i = 1; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (exp_q[i-1].rnw && exp_q[i].rnw && !plan_q[i-1].err)
                check($sformatf("%s_poll_gap%0d", name, i), ((obs_cyc_q[i] - obs_cyc_q[i-1]) >= GAP), 1);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int n;
        string nm;

        ready_mode_sel = 1;
        clear_errs();
        build_plan(0, 0);
        start_seq("clean", 1'b0);
        finish_seq("clean");

        build_plan(2, 0);
        start_seq("lock001", 1'b0);
        finish_seq("lock001");

        clear_errs();
        wr_err[2] = 2;
        build_plan(0, 0);
        start_seq("err2x2", 1'b0);
        finish_seq("err2x2");

        wr_err[2] = RMAX + 1;
        build_plan(0, 0);
        start_seq("errfault", 1'b0);
        finish_seq("errfault");

        clear_errs();
        build_plan(PMAX, 0);
        start_seq("nolock", 1'b0);
        finish_seq("nolock");

        ready_mode_sel = 2;
        build_plan(0, 0);
        start_seq("stall", 1'b1);
        finish_seq("stall");

        ready_mode_sel = 1;
        build_plan(0, 0);
        slow_rsp = 1'b1;
        start_seq("midrst_a", 1'b0);
        n = 0;
        while (dbg_state != ST_POLL_WAIT && n < 5000) begin
            step();
            n++;
        end
        check("midrst_reach_poll", (n < 5000), 1);
        reset = 1'b1;
        step();
        check("midrst_valid", cmd_valid, 0);
        check("midrst_busy", busy, 1);
        slow_rsp = 1'b0;
        start_seq("midrst_b", 1'b0);
        finish_seq("midrst_b");

        ready_mode_sel = 2;
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < NUM_REGS; i++)
                wr_err[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, RMAX)) : 0;
            if ($urandom_range(0, 5) == 0) wr_err[$urandom_range(0, NUM_REGS - 1)] = RMAX + 1;
            build_plan(int'($urandom_range(0, PMAX)), int'($urandom_range(0, 2)));
            nm = $sformatf("rand%0d", it);
            start_seq(nm, 1'b0);
            finish_seq(nm);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
